// File: rtl/key_debounce_pkg.sv
// Shared definitions for the pushbutton debouncer: FSM state encoding and
// default timing for the 50 MHz board clock.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  // 20 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
  localparam int DEF_DEB_CYC = 1000000;
  localparam int DEF_REP_DLY = 25000000;
  localparam int DEF_REP_PER = 5000000;
  localparam int DEF_CNT_W   = 25;

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchronizer for a single asynchronous input, with a
// configurable reset value so idle inputs power up in their inactive level.
module sync2_ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/key_debounce.sv
// Pushbutton conditioner: synchronizes an active-low key, debounces press and
// release, and emits one registered strobe per press plus optional auto-repeat.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC,
  parameter int REP_DLY = DEF_REP_DLY,
  parameter int REP_PER = DEF_REP_PER,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY_N,
  input  logic REP_EN,
  output logic PRESSED,
  output logic PULSE
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REP_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REP_PER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             key_n_sync_s;
  logic             key_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] deb_cnt_r;
  logic [CNT_W-1:0] deb_nxt_s;
  logic [CNT_W-1:0] rep_cnt_r;
  logic [CNT_W-1:0] rep_nxt_s;
  logic [CNT_W-1:0] rep_last_s;
  logic             first_rep_r;
  logic             first_nxt_s;
  logic             rep_step_s;
  logic             pressed_r;
  logic             pressed_nxt_s;
  logic             pulse_r;
  logic             pulse_nxt_s;

  sync2_ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(CLK),
    .rst(RST),
    .d  (KEY_N),
    .q  (key_n_sync_s)
  );

  assign key_s      = ~key_n_sync_s;
  assign rep_last_s = first_rep_r ? DLY_LAST : PER_LAST;

  // Next-state, counter and strobe decode
  always_comb begin
    state_nxt_s = state_r;
    deb_nxt_s   = deb_cnt_r;
    rep_nxt_s   = rep_cnt_r;
    first_nxt_s = first_rep_r;
    pulse_nxt_s = 1'b0;
    rep_step_s  = 1'b0;

    case (state_r)
      IDLE: begin
        deb_nxt_s = CNT_ZERO;
        if (key_s) begin
          state_nxt_s = PRESS_CHK;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRESS_CHK: begin
        if (!key_s) begin
          state_nxt_s = IDLE;
          deb_nxt_s   = CNT_ZERO;
        end else if (deb_cnt_r == DEB_LAST) begin
          state_nxt_s = HELD;
          pulse_nxt_s = 1'b1;
          rep_nxt_s   = CNT_ZERO;
          first_nxt_s = 1'b1;
        end else begin
          deb_nxt_s = deb_cnt_r + CNT_ONE;
        end
      end
      HELD: begin
        if (!key_s) begin
          state_nxt_s = REL_CHK;
          deb_nxt_s   = CNT_ZERO;
        end else begin
          rep_step_s = 1'b1;
        end
      end
      REL_CHK: begin
        // A release glitch only freezes the repeat timer while the key reads released
        if (key_s) begin
          state_nxt_s = HELD;
          rep_step_s  = 1'b1;
        end else if (deb_cnt_r == DEB_LAST) begin
          state_nxt_s = IDLE;
          deb_nxt_s   = CNT_ZERO;
        end else begin
          deb_nxt_s = deb_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        deb_nxt_s   = CNT_ZERO;
        rep_nxt_s   = CNT_ZERO;
        first_nxt_s = 1'b1;
      end
    endcase

    if (rep_step_s) begin
      if (REP_EN) begin
        if (rep_cnt_r == rep_last_s) begin
          pulse_nxt_s = 1'b1;
          rep_nxt_s   = CNT_ZERO;
          first_nxt_s = 1'b0;
        end else begin
          rep_nxt_s = rep_cnt_r + CNT_ONE;
        end
      end else begin
        rep_nxt_s   = CNT_ZERO;
        first_nxt_s = 1'b1;
      end
    end else begin
      rep_nxt_s = rep_nxt_s;
    end

    pressed_nxt_s = (state_nxt_s == HELD) || (state_nxt_s == REL_CHK);
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      deb_cnt_r   <= CNT_ZERO;
      rep_cnt_r   <= CNT_ZERO;
      first_rep_r <= 1'b1;
      pressed_r   <= 1'b0;
      pulse_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      deb_cnt_r   <= deb_nxt_s;
      rep_cnt_r   <= rep_nxt_s;
      first_rep_r <= first_nxt_s;
      pressed_r   <= pressed_nxt_s;
      pulse_r     <= pulse_nxt_s;
    end
  end

  assign PRESSED = pressed_r;
  assign PULSE   = pulse_r;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: fixed vectors, hand-built timing
// scenarios and random stimulus against a run-length reference model.
module tb_key_debounce;

  localparam int DEB_CYC = 4;
  localparam int REP_DLY = 10;
  localparam int REP_PER = 5;
  localparam int CNT_W   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_n = 1'b1;
  logic rep_en = 1'b0;
  logic pressed;
  logic pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_pulse = 1'b0;

  // reference model state
  logic m_k1 = 1'b0, m_k2 = 1'b0;
  logic m_pressed = 1'b0, m_pulse = 1'b0, m_first = 1'b1;
  int   m_run = 0, m_acc = 0;

  typedef struct {
    logic rst;
    logic key_n;
    logic rep_en;
    logic exp_pressed;
    logic exp_pulse;
  } vec_t;
  vec_t vecs[$];

  key_debounce #(
    .DEB_CYC(DEB_CYC), .REP_DLY(REP_DLY), .REP_PER(REP_PER), .CNT_W(CNT_W)
  ) dut (
    .CLK(clk), .RST(rst), .KEY_N(key_n), .REP_EN(rep_en),
    .PRESSED(pressed), .PULSE(pulse)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Behaviour from the rules: key must read steady for DEB_CYC+1 samples
  // after the two-stage delay; repeat time accrues while held and key reads pressed.
  task automatic model_step();
    logic ks;
    ks = m_k2;
    m_pulse = 1'b0;
    if (rst) begin
      m_k1 = 1'b0; m_k2 = 1'b0; m_pressed = 1'b0;
      m_run = 0; m_acc = 0; m_first = 1'b1;
    end else begin
      m_k2 = m_k1;
      m_k1 = ~key_n;
      if (!m_pressed) begin
        if (ks) begin
          m_run++;
          if (m_run == DEB_CYC + 1) begin
            m_pressed = 1'b1; m_pulse = 1'b1; m_run = 0; m_acc = 0; m_first = 1'b1;
          end
        end else m_run = 0;
      end else if (!ks) begin
        m_run++;
        if (m_run == DEB_CYC + 1) begin
          m_pressed = 1'b0; m_run = 0;
        end
      end else begin
        m_run = 0;
        if (rep_en) begin
          m_acc++;
          if (m_acc == (m_first ? REP_DLY : REP_PER)) begin
            m_pulse = 1'b1; m_acc = 0; m_first = 1'b0;
          end
        end else begin
          m_acc = 0; m_first = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check("model_pressed", int'(pressed), int'(m_pressed));
    check("model_pulse", int'(pulse), int'(m_pulse));
    check("pulse_twice", int'(pulse && prev_pulse), 0);
    prev_pulse = pulse;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic void add(logic r, logic k, logic e, logic p, logic u);
    vecs.push_back('{r, k, e, p, u});
  endfunction

  initial begin
    int first_at, cnt, fall_at, t, low_hold;
    int offs[$];
    int exp_rep[7];
    int exp_glt[3];
    logic bounce[7];

    // reset with key held, then acceptance after edge 7, then release after edge 7
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    foreach (vecs[i]) begin
      rst = vecs[i].rst; key_n = vecs[i].key_n; rep_en = vecs[i].rep_en;
      tick();
      check($sformatf("vec%0d_pressed", i), int'(pressed), int'(vecs[i].exp_pressed));
      check($sformatf("vec%0d_pulse", i), int'(pulse), int'(vecs[i].exp_pulse));
    end
    ticks(5);

    // clean press, 50+ cycle hold without repeat
    key_n = 1'b0; first_at = 0; cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (pulse) begin cnt++; if (first_at == 0) first_at = i; end
    end
    check("clean_latency", first_at, DEB_CYC + 3);
    check("clean_pulses", cnt, 1);
    key_n = 1'b1; fall_at = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!pressed && fall_at == 0) fall_at = i;
    end
    check("release_latency", fall_at, DEB_CYC + 3);

    // bounce then steady low
    bounce = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    cnt = 0; first_at = 0;
    for (int i = 0; i < 7; i++) begin
      key_n = bounce[i]; tick(); if (pulse) cnt++;
    end
    key_n = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (pulse) begin cnt++; if (first_at == 0) first_at = i; end
    end
    check("bounce_latency", first_at, DEB_CYC + 3);
    check("bounce_pulses", cnt, 1);
    key_n = 1'b1; ticks(15);

    // auto-repeat schedule
    exp_rep = '{10, 15, 20, 25, 30, 35, 40};
    rep_en = 1'b1; key_n = 1'b0; t = 0;
    for (int i = 1; i <= 20 && t == 0; i++) begin tick(); if (pulse) t = cyc; end
    check("repeat_first_seen", int'(t != 0), 1);
    offs.delete();
    for (int i = 1; i <= 40; i++) begin tick(); if (pulse) offs.push_back(cyc - t); end
    check("repeat_count", offs.size(), 7);
    for (int i = 0; i < 7; i++)
      check($sformatf("repeat_off%0d", i), (i < offs.size()) ? offs[i] : -1, exp_rep[i]);
    key_n = 1'b1; ticks(15);

    // release glitch of 2 cycles in HELD shifts the repeat schedule by 2
    exp_glt = '{12, 17, 22};
    key_n = 1'b0; t = 0;
    for (int i = 1; i <= 20 && t == 0; i++) begin tick(); if (pulse) t = cyc; end
    check("glitch_first_seen", int'(t != 0), 1);
    offs.delete(); low_hold = 0;
    for (int i = 1; i <= 24; i++) begin
      key_n = (i == 3 || i == 4) ? 1'b1 : 1'b0;
      tick();
      if (pulse) offs.push_back(cyc - t);
      if (!pressed) low_hold++;
    end
    check("glitch_pressed_drop", low_hold, 0);
    check("glitch_count", offs.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("glitch_off%0d", i), (i < offs.size()) ? offs[i] : -1, exp_glt[i]);
    key_n = 1'b1; rep_en = 1'b0; ticks(15);

    // five presses driving a downstream counter
    cnt = 0;
    for (int p = 0; p < 5; p++) begin
      key_n = 1'b0;
      for (int i = 0; i < 12; i++) begin tick(); if (pulse) cnt++; end
      key_n = 1'b1;
      for (int i = 0; i < 12; i++) begin tick(); if (pulse) cnt++; end
    end
    check("counter_value", cnt, 5);
    check("counter_hex0", int'(seg7(4'(cnt))), int'(7'b0010010));

    // random stimulus against the model
    for (int n = 0; n < 400; n++) begin
      int len;
      key_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) rep_en = ~rep_en;
      len = (key_n == 1'b0 && $urandom_range(0, 3) == 0) ? $urandom_range(12, 40)
                                                           : $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        rst = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
        tick();
      end
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
